// File: rtl/apb4_req_bridge.sv
// APB4 requester: one valid/ready request becomes one SETUP/ACCESS transfer; response held until rsp_ready_i.
// Latency: accept at N, psel N+1, penable N+2, rsp_valid N+3 plus wait states; req_ready_o only in IDLE.
module apb4_req_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic [2:0]            pprot_nxt;
  logic                  psel_nxt, penable_nxt, pwrite_nxt;
  logic [DATA_WIDTH-1:0] pwdata_nxt, rdata_nxt;
  logic [SW-1:0]         pstrb_nxt;
  logic                  rsp_valid_nxt, err_nxt, timeout_nxt;
  logic                  timeout_hit;

  assign req_ready_o = (state == IDLE);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    paddr_nxt     = paddr_o;
    pprot_nxt     = pprot_o;
    psel_nxt      = psel_o;
    penable_nxt   = penable_o;
    pwrite_nxt    = pwrite_o;
    pwdata_nxt    = pwdata_o;
    pstrb_nxt     = pstrb_o;
    rsp_valid_nxt = rsp_valid_o;
    rdata_nxt     = rsp_rdata_o;
    err_nxt       = rsp_err_o;
    timeout_nxt   = rsp_timeout_o;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          paddr_nxt   = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
          pwrite_nxt  = req_write_i;
          pprot_nxt   = req_prot_i;
          pwdata_nxt  = req_write_i ? req_wdata_i : '0;
          pstrb_nxt   = req_write_i ? req_strb_i : '0;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        // pready takes priority over a timeout expiring in the same cycle
        if (pready_i) begin
          rdata_nxt     = pwrite_o ? '0 : prdata_i;
          err_nxt       = pslverr_i;
          timeout_nxt   = 1'b0;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end else if (timeout_hit) begin
          rdata_nxt     = '0;
          err_nxt       = 1'b1;
          timeout_nxt   = 1'b1;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      paddr_o       <= '0;
      pprot_o       <= '0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      pwdata_o      <= '0;
      pstrb_o       <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      paddr_o       <= paddr_nxt;
      pprot_o       <= pprot_nxt;
      psel_o        <= psel_nxt;
      penable_o     <= penable_nxt;
      pwrite_o      <= pwrite_nxt;
      pwdata_o      <= pwdata_nxt;
      pstrb_o       <= pstrb_nxt;
      rsp_valid_o   <= rsp_valid_nxt;
      rsp_rdata_o   <= rdata_nxt;
      rsp_err_o     <= err_nxt;
      rsp_timeout_o <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_apb4_req_bridge.sv
// Bench for apb4_req_bridge: directed requests, expected responses queued at issue and popped by a monitor.
// A second instance with the timeout disabled checks that a stalled transfer stays pending.
module tb_apb4_req_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic [2:0]  req_prot = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite, pready = 1'b0, pslverr;
  logic [3:0]  pstrb;

  logic        req0_valid = 1'b0, req0_ready, rsp0_valid, rsp0_err, rsp0_timeout;
  logic [31:0] rsp0_rdata, paddr0, pwdata0;
  logic [2:0]  pprot0;
  logic        psel0, penable0, pwrite0;
  logic [3:0]  pstrb0;

  int          slv_waits = 0;
  int          acc_cnt = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  apb4_req_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb), .req_prot_i(req_prot),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );

  apb4_req_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req0_valid), .req_ready_o(req0_ready), .req_write_i(1'b0),
    .req_addr_i(32'h0000_0008), .req_wdata_i(32'h0), .req_strb_i(4'h0), .req_prot_i(3'h0),
    .rsp_valid_o(rsp0_valid), .rsp_ready_i(1'b1), .rsp_rdata_o(rsp0_rdata),
    .rsp_err_o(rsp0_err), .rsp_timeout_o(rsp0_timeout),
    .paddr_o(paddr0), .pprot_o(pprot0), .psel_o(psel0), .penable_o(penable0), .pwrite_o(pwrite0),
    .pwdata_o(pwdata0), .pstrb_o(pstrb0), .pready_i(1'b0), .prdata_i(32'hFFFF_FFFF), .pslverr_i(1'b1)
  );

  // Completer model: pready after slv_waits low ACCESS cycles; data is junk while not ready.
  always @(negedge clk) begin
    if (psel && penable) begin
      pready  = (acc_cnt >= slv_waits);
      acc_cnt = acc_cnt + 1;
    end else begin
      pready  = 1'b0;
      acc_cnt = 0;
    end
    prdata  = pready ? slv_rdata : 32'hBAD0_BAD0;
    pslverr = pready ? slv_err : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got rdata 0x%0h with no response expected", rsp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] sb, input logic [2:0] pr);
    bit seen = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_strb = sb; req_prot = pr;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = req_ready;
    end
    if (!seen) check("req_ready_wait", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) check("rsp_valid_wait", 64'(rsp_valid), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pen_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_psel", 64'(psel), 64'(0));
    check("rst_penable", 64'(penable), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));
    check("rst_paddr", 64'(paddr), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1 rst = 1'b0;

    // zero-wait write; completer drives nonzero prdata that must not leak into the response
    slv_waits = 0; slv_rdata = 32'h1234_5678;
    exp_q.push_back('{32'h0, 1'b0, 1'b0});
    issue(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 3'b010);
    @(negedge clk);
    check("w_psel_n1", 64'(psel), 64'(1));
    check("w_penable_n1", 64'(penable), 64'(0));
    check("w_paddr", 64'(paddr), 64'h4);
    check("w_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    check("w_pstrb", 64'(pstrb), 64'hF);
    check("w_pprot", 64'(pprot), 64'h2);
    check("w_req_ready_busy", 64'(req_ready), 64'(0));
    @(negedge clk);
    check("w_penable_n2", 64'(penable), 64'(1));
    @(negedge clk);
    check("w_rsp_valid_n3", 64'(rsp_valid), 64'(1));
    check("w_psel_n3", 64'(psel), 64'(0));

    // read with 3 wait states
    slv_waits = 3; slv_rdata = 32'h0000_00FF;
    exp_q.push_back('{32'h0000_00FF, 1'b0, 1'b0});
    issue(1'b0, 32'h0000_0000, 32'hAAAA_AAAA, 4'hF, 3'b000);
    @(negedge clk);
    check("r_pstrb", 64'(pstrb), 64'h0);
    check("r_pwdata", 64'(pwdata), 64'h0);
    check("r_pwrite", 64'(pwrite), 64'h0);
    pen_cnt = 0;
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      if (psel && penable) pen_cnt++;
      if (i == 5) check("r_rsp_valid_n5", 64'(rsp_valid), 64'(0));
      if (i == 6) check("r_rsp_valid_n6", 64'(rsp_valid), 64'(1));
    end
    check("r_penable_cycles", 64'(pen_cnt), 64'(4));

    // completer error
    slv_waits = 0; slv_err = 1'b1;
    exp_q.push_back('{32'h0, 1'b1, 1'b0});
    issue(1'b1, 32'h0000_0010, 32'h5555_0000, 4'hC, 3'b001);
    wait_rsp();
    slv_err = 1'b0;

    // timeout after 8 ACCESS cycles
    slv_waits = 1000;
    exp_q.push_back('{32'h0, 1'b1, 1'b1});
    issue(1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'b000);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 9) begin
        check("to_psel_n9", 64'(psel), 64'(1));
        check("to_penable_n9", 64'(penable), 64'(1));
        check("to_rsp_valid_n9", 64'(rsp_valid), 64'(0));
      end
      if (i == 10) begin
        check("to_psel_n10", 64'(psel), 64'(0));
        check("to_penable_n10", 64'(penable), 64'(0));
        check("to_rsp_valid_n10", 64'(rsp_valid), 64'(1));
      end
    end

    // timeout disabled: transfer stays pending
    @(posedge clk); #1 req0_valid = 1'b1;
    @(negedge clk);
    check("t0_req_ready", 64'(req0_ready), 64'(1));
    @(posedge clk); #1 req0_valid = 1'b0;
    repeat (1000) @(negedge clk);
    check("t0_psel", 64'(psel0), 64'(1));
    check("t0_penable", 64'(penable0), 64'(1));
    check("t0_rsp_valid", 64'(rsp0_valid), 64'(0));

    // response backpressure with a second request waiting
    slv_waits = 0; slv_rdata = 32'h0000_5A5A;
    rsp_ready = 1'b0;
    exp_q.push_back('{32'h0000_5A5A, 1'b0, 1'b0});
    issue(1'b0, 32'h0000_0030, 32'h0, 4'h0, 3'b000);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0040;
    req_wdata = 32'h1111_2222; req_strb = 4'h3; req_prot = 3'b100;
    exp_q.push_back('{32'h0, 1'b0, 1'b0});
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      check("bp_rsp_rdata", 64'(rsp_rdata), 64'h5A5A);
      check("bp_req_ready", 64'(req_ready), 64'(0));
      check("bp_psel", 64'(psel), 64'(0));
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_psel_release", 64'(psel), 64'(0));
    @(negedge clk);
    check("bp_req_ready_after", 64'(req_ready), 64'(1));
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("bp2_psel", 64'(psel), 64'(1));
    check("bp2_paddr", 64'(paddr), 64'h40);
    check("bp2_pstrb", 64'(pstrb), 64'h3);
    wait_rsp();

    // reset during a wait state, then an unaligned request
    slv_waits = 20;
    issue(1'b0, 32'h0000_0050, 32'h0, 4'h0, 3'b000);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rr_psel", 64'(psel), 64'(0));
    check("rr_penable", 64'(penable), 64'(0));
    check("rr_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rr_req_ready", 64'(req_ready), 64'(1));
    slv_waits = 0; slv_rdata = 32'h0000_0077;
    exp_q.push_back('{32'h0000_0077, 1'b0, 1'b0});
    issue(1'b0, 32'h0000_0013, 32'h0, 4'h0, 3'b000);
    @(negedge clk);
    check("rr_paddr_aligned", 64'(paddr), 64'h10);
    wait_rsp();
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
